// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - access legality check (funct3 + alignment)
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_RMW_WRITE = 1'b1
  } lsu_state_e;

  // Legal when funct3 is defined for the op type and the address is naturally aligned.
  function automatic logic lsu_legal(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic f3_ok;
    logic align_ok;
    if (we) begin
      f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    case (funct3)
      F3_H, F3_HU: align_ok = ~addr_lo[0];
      F3_W:        align_ok = (addr_lo == 2'b00);
      default:     align_ok = 1'b1;
    endcase
    return f3_ok && align_ok;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half lane from a memory word and
// sign- or zero-extends it according to funct3.
// Ports:
//   word_i    - word read from memory
//   addr_lo_i - byte offset within the word
//   funct3_i  - RV32I load funct3
//   data_o    - extended load result (0 for undefined funct3)
module mem_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [4:0]      lane_sh;
  logic [XLEN-1:0] shifted;

  // Little-endian lanes: shifting the word right by 8*offset brings the
  // addressed byte (or the aligned half) down to bit 0.
  assign lane_sh = {addr_lo_i, 3'b000};
  assign shifted = word_i >> lane_sh;

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}},  shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory-stage load/store unit driving a word-addressed data memory with
// combinational read and clocked write.
//   - loads: lane extraction with sign/zero extension, 1-cycle response
//   - SW: direct word write, 1-cycle response
//   - SB/SH: read-modify-write over two cycles, pipeline stalled via busy
//   - misaligned or illegal funct3: fault response, memory untouched
// Ports:
//   clk, reset              - clock, synchronous active-low reset
//   req_valid/we/funct3/addr/wdata - request from the MEM stage
//   busy                    - high during the RMW write cycle
//   resp_valid/rdata/fault  - registered completion
//   mem_A/mem_WD/mem_WE     - memory address, write data, write enable
//   mem_RD                  - memory read data
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  lsu_state_e        state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_fault_q, resp_fault_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              accept;
  logic              legal;
  logic              is_sw;
  logic [DATA_W-1:0] load_data;
  logic [4:0]        lane_sh;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane_data;
  logic [DATA_W-1:0] merged;
  logic              mem_we_raw;

  assign busy   = (state_q == S_RMW_WRITE);
  assign accept = req_valid && (state_q == S_IDLE);
  assign legal  = lsu_legal(req_we, req_funct3, req_addr[1:0]);
  assign is_sw  = req_we && (req_funct3 == F3_W);

  mem_load_align u_align (
    .word_i    (mem_RD),
    .addr_lo_i (req_addr[1:0]),
    .funct3_i  (req_funct3),
    .data_o    (load_data)
  );

  // Sub-word store merge: replace the addressed lane(s) of the read word.
  assign lane_sh = {req_addr[1:0], 3'b000};

  always_comb begin
    lane_mask = DATA_W'(8'hFF) << lane_sh;
    lane_data = DATA_W'(req_wdata[7:0]) << lane_sh;
    if (req_funct3 == F3_H) begin
      lane_mask = DATA_W'(16'hFFFF) << lane_sh;
      lane_data = DATA_W'(req_wdata[15:0]) << lane_sh;
    end
  end

  assign merged = (mem_RD & ~lane_mask) | (lane_data & lane_mask);

  // Next-state, response and memory-port logic.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_fault_d = 1'b0;
    merge_d      = merge_q;
    addr_d       = addr_q;
    mem_A        = req_addr;
    mem_WD       = '0;
    mem_we_raw   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!legal) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (!req_we) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end else if (is_sw) begin
            mem_WD       = req_wdata;
            mem_we_raw   = 1'b1;
            resp_valid_d = 1'b1;
          end else begin
            merge_d = merged;
            addr_d  = req_addr;
            state_d = S_RMW_WRITE;
          end
        end
      end
      S_RMW_WRITE: begin
        mem_A        = addr_q;
        mem_WD       = merge_q;
        mem_we_raw   = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gate the write while reset is held so a pending RMW write is dropped.
  assign mem_WE = mem_we_raw && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      merge_q      <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      merge_q      <= merge_d;
      addr_q       <= addr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small behavioural data memory.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  // Data memory: 16 words, combinational read (0 in reset), clocked write.
  logic [31:0] mem [0:15];
  logic        init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899AABB;
      mem[3] <= 32'h11223344;
    end else if (mem_WE) begin
      mem[mem_A[5:2]] <= mem_WD;
    end
  end

  assign mem_RD = reset ? mem[mem_A[5:2]] : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic idle_req;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  // Single-cycle op: check the memory port during the request cycle and
  // the response one edge later.
  task automatic apply_vec(input vec_t v);
    set_req(v.we, v.f3, v.addr, v.wdata);
    #3;
    chk({v.name, " mem_WE"}, 32'(mem_WE), 32'(v.exp_we));
    chk({v.name, " mem_WD"}, mem_WD, v.exp_wd);
    step;
    chk({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({v.name, " resp_fault"}, 32'(resp_fault), 32'(v.exp_fault));
    chk({v.name, " resp_rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, " busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{"LB@1",    1'b0, F3_B,  32'h1,  32'h0, 32'hFFFFFFAA, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"LBU@1",   1'b0, F3_BU, 32'h1,  32'h0, 32'h000000AA, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{"LH@2",    1'b0, F3_H,  32'h2,  32'h0, 32'hFFFF8899, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{"LW@0",    1'b0, F3_W,  32'h0,  32'h0, 32'h8899AABB, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"LHU@2",   1'b0, F3_HU, 32'h2,  32'h0, 32'h00008899, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"LB@3",    1'b0, F3_B,  32'h3,  32'h0, 32'hFFFFFF88, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{"LBU@0",   1'b0, F3_BU, 32'h0,  32'h0, 32'h000000BB, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{"LH@0",    1'b0, F3_H,  32'h0,  32'h0, 32'hFFFFAABB, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"SH@1",    1'b1, F3_H,  32'h1,  32'h0000BEEF, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{"LW@2",    1'b0, F3_W,  32'h2,  32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{"LD_F3_3", 1'b0, 3'd3,  32'h0,  32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{"ST_F3_4", 1'b1, F3_BU, 32'h0,  32'h12345678, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{"SW@10",   1'b1, F3_W,  32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[13] = '{"LW@10",   1'b0, F3_W,  32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};

    // Reset and memory preload.
    idle_req();
    reset    = 1'b0;
    init_mem = 1'b1;
    step;
    step;
    init_mem = 1'b0;
    #3;
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_fault", 32'(resp_fault), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_WE", 32'(mem_WE), 32'd0);
    chk("rst mem_WD", mem_WD, 32'h0);
    reset = 1'b1;
    step;

    // Table: loads, faults, SW/LW pair.
    for (int i = 0; i < 14; i++) apply_vec(vecs[i]);
    idle_req();
    step;
    chk("idle resp_valid", 32'(resp_valid), 32'd0);
    chk("faults word0 intact", mem[0], 32'h8899AABB);

    // SB 0x123456CC @0x6 over word1 = 0.
    set_req(1'b1, F3_B, 32'h6, 32'h123456CC);
    #3;
    chk("sb read mem_WE", 32'(mem_WE), 32'd0);
    chk("sb read busy", 32'(busy), 32'd0);
    step;
    chk("sb rmw busy", 32'(busy), 32'd1);
    chk("sb rmw resp_valid", 32'(resp_valid), 32'd0);
    idle_req();
    #3;
    chk("sb rmw mem_WE", 32'(mem_WE), 32'd1);
    chk("sb rmw mem_WD", mem_WD, 32'h00CC0000);
    chk("sb rmw mem_A", mem_A, 32'h6);
    step;
    chk("sb done busy", 32'(busy), 32'd0);
    chk("sb done resp_valid", 32'(resp_valid), 32'd1);
    chk("sb done resp_rdata", resp_rdata, 32'h0);
    chk("sb done resp_fault", 32'(resp_fault), 32'd0);
    chk("sb word1", mem[1], 32'h00CC0000);
    apply_vec('{"LW@4 after SB", 1'b0, F3_W, 32'h4, 32'h0, 32'h00CC0000, 1'b0, 1'b0, 32'h0});
    idle_req();
    step;
    chk("sb post resp_valid", 32'(resp_valid), 32'd0);

    // SW then back-to-back LW to the same word.
    set_req(1'b1, F3_W, 32'h8, 32'hDEADBEEF);
    #3;
    chk("sw mem_WE", 32'(mem_WE), 32'd1);
    chk("sw mem_WD", mem_WD, 32'hDEADBEEF);
    step;
    chk("sw resp_valid", 32'(resp_valid), 32'd1);
    chk("sw resp_rdata", resp_rdata, 32'h0);
    set_req(1'b0, F3_W, 32'h8, 32'h0);
    #3;
    chk("b2b lw mem_WE", 32'(mem_WE), 32'd0);
    step;
    chk("b2b lw resp_valid", 32'(resp_valid), 32'd1);
    chk("b2b lw resp_rdata", resp_rdata, 32'hDEADBEEF);
    idle_req();
    step;
    chk("b2b end resp_valid", 32'(resp_valid), 32'd0);

    // Reset during RMW_WRITE of SH 0xBEEF @0xC: write dropped.
    set_req(1'b1, F3_H, 32'hC, 32'h0000BEEF);
    step;
    chk("rstmid busy", 32'(busy), 32'd1);
    idle_req();
    reset = 1'b0;
    #3;
    chk("rstmid mem_WE", 32'(mem_WE), 32'd0);
    step;
    chk("rstmid word3", mem[3], 32'h11223344);
    chk("rstmid busy after", 32'(busy), 32'd0);
    chk("rstmid resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid resp_rdata", resp_rdata, 32'h0);
    chk("rstmid resp_fault", 32'(resp_fault), 32'd0);
    chk("rstmid mem_WD", mem_WD, 32'h0);
    reset = 1'b1;
    step;
    chk("rstmid no late resp", 32'(resp_valid), 32'd0);
    chk("rstmid word3 still", mem[3], 32'h11223344);

    // Legal SH 0xBEEF @0xE over 0x11223344.
    set_req(1'b1, F3_H, 32'hE, 32'h1234BEEF);
    step;
    idle_req();
    #3;
    chk("sh rmw mem_WD", mem_WD, 32'hBEEF3344);
    step;
    chk("sh resp_valid", 32'(resp_valid), 32'd1);
    apply_vec('{"LW@C after SH", 1'b0, F3_W, 32'hC, 32'h0, 32'hBEEF3344, 1'b0, 1'b0, 32'h0});

    // LW held during busy: accepted only once busy drops.
    set_req(1'b1, F3_B, 32'h0, 32'h000000AB);
    step;
    chk("hold busy", 32'(busy), 32'd1);
    set_req(1'b0, F3_W, 32'h0, 32'h0);
    #3;
    chk("hold rmw mem_WE", 32'(mem_WE), 32'd1);
    chk("hold rmw mem_WD", mem_WD, 32'h8899AAAB);
    step;
    chk("hold sb resp_valid", 32'(resp_valid), 32'd1);
    chk("hold sb resp_rdata", resp_rdata, 32'h0);
    chk("hold busy dropped", 32'(busy), 32'd0);
    step;
    chk("hold lw resp_valid", 32'(resp_valid), 32'd1);
    chk("hold lw resp_rdata", resp_rdata, 32'h8899AAAB);
    idle_req();
    step;
    chk("hold single resp", 32'(resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
